// File: rtl/uart_cmd_parser.sv
// Byte-level command-frame parser: write/read/run frames from UART RX, read-back
// via UART TX, register write strobes and error reporting with an inter-byte timeout.
module uart_cmd_parser #(
  parameter int         DATA_BYTES  = 16,
  parameter int         N_ADDR      = 4,
  parameter int         TIMEOUT_CYC = 2_000_000,
  parameter logic [7:0] CMD_WR      = 8'h10,
  parameter logic [7:0] CMD_RD      = 8'h20,
  parameter logic [7:0] CMD_RUN     = 8'h40,
  localparam int        DATA_W      = 8 * DATA_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              wr_en,
  output logic [7:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [7:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              run,
  input  logic              busy,
  output logic              err_pulse,
  output logic [2:0]        err_code,
  output logic [2:0]        dbg_state
);

  localparam int         CNT_W     = $clog2(DATA_BYTES + 1);
  localparam int         TO_W      = $clog2(TIMEOUT_CYC);
  localparam logic [8:0] N_ADDR_L  = 9'(N_ADDR);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WRITE, S_RD_REQ, S_RD_LOAD, S_TX
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic                r_is_rd;
  logic [7:0]          r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [DATA_W-1:0]   r_payload;
  logic [DATA_W-1:0]   r_tx_shift;
  logic                r_run;
  logic                r_err_pulse;
  logic [2:0]          r_err_code;

  logic                w_is_frame_cmd;
  logic                w_addr_ok;
  logic                w_in_frame;
  logic                w_timeout;
  logic                w_overrun;
  logic                w_err_set;
  logic [2:0]          w_err_val;

  assign w_is_frame_cmd = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  assign w_addr_ok      = {1'b0, r_addr} < N_ADDR_L;
  assign w_in_frame     = (r_state == S_ADDR) || (r_state == S_DATA);
  // The TIMEOUT_CYC-th consecutive idle cycle expires; a byte in that cycle wins.
  assign w_timeout      = w_in_frame && !rx_valid && (r_to_cnt == TO_LAST);
  assign w_overrun      = rx_valid && ((r_state == S_WRITE) || (r_state == S_RD_REQ) ||
                                       (r_state == S_RD_LOAD) || (r_state == S_TX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:    if (rx_valid && w_is_frame_cmd) w_state_nx = S_ADDR;
      S_ADDR:    if (w_timeout) w_state_nx = S_IDLE;
                 else if (rx_valid) w_state_nx = r_is_rd ? S_RD_REQ : S_DATA;
      S_DATA:    if (w_timeout) w_state_nx = S_IDLE;
                 else if (rx_valid && (r_cnt == LAST_BYTE)) w_state_nx = S_WRITE;
      S_WRITE:   w_state_nx = S_IDLE;
      S_RD_REQ:  w_state_nx = w_addr_ok ? S_RD_LOAD : S_IDLE;
      S_RD_LOAD: w_state_nx = S_TX;
      S_TX:      if (tx_ready && (r_cnt == LAST_BYTE)) w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  // TX handshake: tx_valid stays high with tx_data stable until a cycle where
  // tx_valid && tx_ready; that cycle transfers the byte and the next one is shown.
  always_comb begin
    wr_en    = (r_state == S_WRITE) && w_addr_ok;
    tx_valid = (r_state == S_TX);
    tx_data  = r_tx_shift[7:0];
  end

  always_comb begin
    w_err_set = 1'b0;
    w_err_val = 3'd0;
    if (w_timeout) begin
      w_err_set = 1'b1;
      w_err_val = 3'd3;
    end else if (w_overrun) begin
      w_err_set = 1'b1;
      w_err_val = 3'd4;
    end else if ((r_state == S_IDLE) && rx_valid && (rx_data == CMD_RUN) && busy) begin
      w_err_set = 1'b1;
      w_err_val = 3'd5;
    end else if ((r_state == S_IDLE) && rx_valid && !w_is_frame_cmd && (rx_data != CMD_RUN)) begin
      w_err_set = 1'b1;
      w_err_val = 3'd1;
    end else if (((r_state == S_WRITE) || (r_state == S_RD_REQ)) && !w_addr_ok) begin
      w_err_set = 1'b1;
      w_err_val = 3'd2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_rd     <= 1'b0;
      r_addr      <= 8'd0;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_payload   <= '0;
      r_tx_shift  <= '0;
      r_run       <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_code  <= 3'd0;
    end else begin
      r_run       <= 1'b0;
      r_err_pulse <= w_err_set;
      if (w_err_set) r_err_code <= w_err_val;
      r_to_cnt <= (w_in_frame && !rx_valid && !w_timeout) ? r_to_cnt + TO_W'(1) : '0;
      case (r_state)
        S_IDLE: if (rx_valid) begin
          if (w_is_frame_cmd) r_is_rd <= (rx_data == CMD_RD);
          if ((rx_data == CMD_RUN) && !busy) r_run <= 1'b1;
        end
        S_ADDR: if (rx_valid && !w_timeout) begin
          r_addr <= rx_data;
          r_cnt  <= '0;
        end
        S_DATA: if (rx_valid) begin
          r_payload <= {rx_data, r_payload[DATA_W-1:8]};
          r_cnt     <= r_cnt + CNT_W'(1);
        end
        S_RD_LOAD: begin
          r_tx_shift <= rd_data;
          r_cnt      <= '0;
        end
        S_TX: if (tx_ready) begin
          r_tx_shift <= {8'd0, r_tx_shift[DATA_W-1:8]};
          r_cnt      <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign wr_addr   = r_addr;
  assign wr_data   = r_payload;
  assign rd_addr   = r_addr;
  assign run       = r_run;
  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: write, read-back, run, error, timeout,
// overrun and reset-recovery frames with hand-computed expectations.
module tb_uart_cmd_parser;

  localparam int DB = 16;
  localparam int DW = 8 * DB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          wr_en;
  logic [7:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0]    rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          run;
  logic          busy = 1'b0;
  logic          err_pulse;
  logic [2:0]    err_code;
  logic [2:0]    dbg_state;

  uart_cmd_parser #(.DATA_BYTES(DB), .N_ADDR(4), .TIMEOUT_CYC(1000)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .run(run), .busy(busy),
    .err_pulse(err_pulse), .err_code(err_code), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // register fabric model: one-cycle read latency
  logic [DW-1:0] mem [4];
  always @(posedge clk) begin
    rd_data <= (rd_addr < 8'd4) ? mem[rd_addr[1:0]] : '0;
    if (wr_en && wr_addr < 8'd4) mem[wr_addr[1:0]] <= wr_data;
  end

  // monitors and TX scoreboard
  logic [7:0] exp_q[$];
  int         wr_count = 0, run_count = 0, err_count = 0, tx_valid_cycles = 0;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = 8'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en)     wr_count++;
      if (run)       run_count++;
      if (err_pulse) err_count++;
      if (tx_valid)  tx_valid_cycles++;
      if (hold_pending) begin
        check("tx_hold_valid", DW'(tx_valid), DW'(1));
        check("tx_hold_data", DW'(tx_data), DW'(hold_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("tx_extra_byte", DW'(tx_data), DW'(9'h100));
        else check("tx_byte", DW'(tx_data), DW'(exp_q.pop_front()));
      end
      hold_pending = tx_valid && !tx_ready;
      hold_data    = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_write(input logic [7:0] addr, input logic [DW-1:0] payload);
    send_byte(8'h10);
    send_byte(addr);
    for (int k = 0; k < DB; k++) send_byte(payload[8*k +: 8]);
  endtask

  task automatic tx_drain(input int stall, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      for (int t = 0; t < 50 && !tx_valid; t++) begin
        @(posedge clk); #1;
      end
      check("tx_wait", DW'(tx_valid), DW'(1));
      repeat (stall) begin
        @(posedge clk); #1;
      end
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
  endtask

  task automatic expect_read_bytes(input logic [DW-1:0] v);
    for (int k = 0; k < DB; k++) exp_q.push_back(v[8*k +: 8]);
  endtask

  logic [7:0]    wr_bytes [16] = '{8'h3c, 8'h4f, 8'hcf, 8'h09, 8'h88, 8'h15, 8'hf7, 8'hab,
                                   8'ha6, 8'hd2, 8'hae, 8'h28, 8'h16, 8'h15, 8'h7e, 8'h2b};
  logic [DW-1:0] rd_val = 128'h000102030405060708090a0b0c0d0e0f;
  logic [DW-1:0] pay3   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  logic [DW-1:0] pay2   = 128'h11223344_55667788_99aabbcc_ddeeff00;
  int            lat;
  int            tv_before;

  initial begin
    mem[0] = '0; mem[1] = rd_val; mem[2] = '0; mem[3] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_state", DW'(dbg_state), DW'(0));
    check("rst_tx_valid", DW'(tx_valid), DW'(0));
    check("rst_wr_en", DW'(wr_en), DW'(0));
    check("rst_run", DW'(run), DW'(0));
    check("rst_err_code", DW'(err_code), DW'(0));
    check("rst_wr_data", wr_data, DW'(0));

    // write frame from the byte table
    send_byte(8'h10);
    send_byte(8'h00);
    for (int k = 0; k < DB; k++) send_byte(wr_bytes[k]);
    check("wr_en_lat", DW'(wr_en), DW'(1));
    check("wr_addr", DW'(wr_addr), DW'(0));
    check("wr_data", wr_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(posedge clk); #1;
    check("wr_en_one_cycle", DW'(wr_en), DW'(0));
    check("wr_count_1", DW'(wr_count), DW'(1));

    // read-back with 5-cycle stall per byte
    send_byte(8'h20);
    send_byte(8'h01);
    check("rd_lat0", DW'(tx_valid), DW'(0));
    @(posedge clk); #1;
    check("rd_lat1", DW'(tx_valid), DW'(0));
    @(posedge clk); #1;
    check("rd_lat2", DW'(tx_valid), DW'(1));
    expect_read_bytes(rd_val);
    tx_drain(5, DB);
    check("rd_q_empty", DW'(exp_q.size()), DW'(0));
    check("rd_idle", DW'(dbg_state), DW'(0));
    check("rd_tx_valid_off", DW'(tx_valid), DW'(0));

    // run, not busy then busy
    send_byte(8'h40);
    check("run_pulse", DW'(run), DW'(1));
    @(posedge clk); #1;
    check("run_one_cycle", DW'(run), DW'(0));
    busy = 1'b1;
    send_byte(8'h40);
    check("run_busy_none", DW'(run), DW'(0));
    check("run_busy_err", DW'(err_code), DW'(5));
    check("run_busy_pulse", DW'(err_pulse), DW'(1));
    busy = 1'b0;
    check("run_count", DW'(run_count), DW'(1));

    // unknown command
    send_byte(8'h55);
    check("unk_err", DW'(err_code), DW'(1));
    check("unk_state", DW'(dbg_state), DW'(0));

    // bad-address write consumes the payload and writes nothing
    send_write(8'h07, pay3);
    check("badwr_no_en", DW'(wr_en), DW'(0));
    @(posedge clk); #1;
    check("badwr_err", DW'(err_code), DW'(2));
    check("badwr_pulse", DW'(err_pulse), DW'(1));
    check("badwr_count", DW'(wr_count), DW'(1));

    // bad-address read transmits nothing
    tv_before = tx_valid_cycles;
    send_byte(8'h20);
    send_byte(8'h09);
    @(posedge clk); #1;
    check("badrd_err_code", DW'(err_code), DW'(4'd2));
    repeat (5) @(posedge clk);
    #1;
    check("badrd_no_tx", DW'(tx_valid_cycles), DW'(tv_before));
    check("badrd_idle", DW'(dbg_state), DW'(0));

    // timeout after 5 payload bytes
    send_byte(8'h10);
    send_byte(8'h00);
    for (int k = 0; k < 5; k++) send_byte(8'hf0 + 8'(k));
    lat = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk); #1;
      if (err_pulse) begin
        lat = i;
        break;
      end
    end
    check("to_latency", DW'(lat), DW'(1000));
    check("to_err", DW'(err_code), DW'(3));
    check("to_idle", DW'(dbg_state), DW'(0));
    check("to_no_write", DW'(wr_count), DW'(1));
    send_write(8'h03, pay3);
    check("to_next_wr_en", DW'(wr_en), DW'(1));
    check("to_next_addr", DW'(wr_addr), DW'(3));
    check("to_next_data", wr_data, pay3);

    // overrun during TX, TX still completes
    send_byte(8'h20);
    send_byte(8'h01);
    repeat (2) @(posedge clk);
    #1;
    expect_read_bytes(rd_val);
    send_byte(8'h33);
    check("ovr_err", DW'(err_code), DW'(4));
    check("ovr_pulse", DW'(err_pulse), DW'(1));
    check("ovr_state_tx", DW'(dbg_state), DW'(6));
    tx_drain(1, DB);
    check("ovr_q_empty", DW'(exp_q.size()), DW'(0));
    check("ovr_idle", DW'(dbg_state), DW'(0));

    // async reset mid-DATA, then a clean frame
    send_byte(8'h10);
    send_byte(8'h02);
    for (int k = 0; k < 5; k++) send_byte(8'h77);
    rst = 1'b1;
    #1;
    check("rst_mid_state", DW'(dbg_state), DW'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_no_wr", DW'(wr_count), DW'(2));
    send_write(8'h02, pay2);
    check("rst_next_wr_en", DW'(wr_en), DW'(1));
    check("rst_next_addr", DW'(wr_addr), DW'(2));
    check("rst_next_data", wr_data, pay2);
    @(posedge clk); #1;

    check("total_writes", DW'(wr_count), DW'(3));
    check("total_errs", DW'(err_count), DW'(6));
    check("total_runs", DW'(run_count), DW'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Byte-level command-frame parser between the UART RX/TX byte cores and the CRG register/control fabric.
- Successor to the fixed 128-bit key-load/run decoder: payload width, address space and inter-byte timeout are parametrised.
- Adds a read-back command that streams register contents out via the UART TX handshake.
- Adds error reporting for unknown commands, bad addresses, timeouts and overruns.

Parameters:
- DATA_BYTES, 16, payload bytes per write/read frame; DATA_W = 8*DATA_BYTES.
- N_ADDR, 4, number of valid register addresses (0..N_ADDR-1); must be ≤256.
- TIMEOUT_CYC, 2_000_000, max idle cycles between bytes inside a frame (20 ms at 100 MHz).
- CMD_WR, 8'h10, write command code.
- CMD_RD, 8'h20, read command code.
- CMD_RUN, 8'h40, run command code.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous active-high reset.
- rx_data  in  8  received byte from UART RX.
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  tx_data valid; held until tx_ready.
- tx_ready  in  1  UART TX accepts byte when tx_valid&&tx_ready.
- wr_en  out  1  one-cycle register write strobe.
- wr_addr  out  8  write address.
- wr_data  out  DATA_W  write payload.
- rd_addr  out  8  read address.
- rd_data  in  DATA_W  read data, valid one cycle after rd_addr is presented.
- run  out  1  one-cycle start pulse to the AES/CRG core.
- busy  in  1  core busy; run is not issued while high.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  3  1 unknown cmd, 2 bad addr, 3 timeout, 4 overrun, 5 run-while-busy; holds last value.

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, timeout counter 0, shift registers 0.
- States: IDLE, ADDR, DATA, WRITE, RD_REQ, RD_LOAD, TX.
- IDLE, rx_valid:
  - CMD_WR or CMD_RD: latch the command, go to ADDR.
  - CMD_RUN with busy=0: run=1 next cycle; stay IDLE.
  - CMD_RUN with busy=1: err code 5, no run.
  - Any other byte: err code 1, stay IDLE.
- ADDR, rx_valid: latch the address.
  - WR: clear byte count, go to DATA.
  - RD: go to RD_REQ.
- DATA: byte k (k=0 first) goes to payload[8k+7:8k], LSB first. After byte DATA_BYTES-1, go to WRITE.
- WRITE: single cycle, then IDLE.
  - addr < N_ADDR: wr_en=1 with wr_addr/wr_data.
  - Otherwise: no wr_en, err code 2.
  - A bad-address write still consumes its full payload.
- RD_REQ:
  - addr ≥ N_ADDR: err code 2, back to IDLE, nothing transmitted.
  - Otherwise: drive rd_addr, go to RD_LOAD.
- RD_LOAD: capture rd_data into the TX shift register, go to TX.
- TX:
  - Present bytes LSB first.
  - tx_valid stays high and tx_data stays stable until tx_ready.
  - After DATA_BYTES handshakes, tx_valid=0 and go to IDLE.
- Latency:
  - run and wr_en: 1 cycle after the final rx_valid.
  - First tx_valid: 3 cycles after the address byte.
- Timeout (ADDR or DATA only):
  - The counter increments each cycle without rx_valid and clears on rx_valid.
  - On reaching TIMEOUT_CYC: err code 3, go to IDLE, partial payload discarded.
  - rx_valid in the same cycle as expiry: the byte wins and no timeout occurs.
- Overrun: rx_valid during WRITE/RD_REQ/RD_LOAD/TX drops the byte with err code 4; the state is unaffected.
- At most one err_pulse per cycle. Priority: timeout > overrun > other codes.
- Async reset mid-frame or mid-TX: immediate return to IDLE, tx_valid=0, no partial write.

Test Plan:
- Write: bytes 10,00 then 3c,4f,cf,09,88,15,f7,ab,a6,d2,ae,28,16,15,7e,2b → exactly one wr_en, wr_addr=0, wr_data=128'h2b7e151628aed2a6abf7158809cf4f3c.
- Read: preload addr 1 = 128'h000102…0f; send 20,01 with tx_ready stalled 5 cycles per byte → tx bytes 0f,0e,…,00 in order, each stable while stalled; 16 handshakes total, then IDLE.
- Run: 40 with busy=0 → one-cycle run. 40 with busy=1 → no run, err_code=5.
- Errors: 55 → err_code=1. 10,07 (N_ADDR=4) + 16 bytes → no wr_en, err_code=2. 20,09 → err_code=2, no tx_valid.
- Timeout: 10,00 + 5 bytes then silence (TIMEOUT_CYC=1000 in bench) → err_code=3 at cycle 1000. A following full write frame succeeds.
- Robustness: rx byte during TX → err_code=4 and TX completes. Reset asserted mid-DATA → no wr_en; the next frame parses correctly.
